rd_responder: RTL and testbench

Read-side responder for the team's go/rd/ws/ds read handshake. It holds `ws` high while a read is pending and drops it once the addressed word is available on `rdata`. It sits between the read-initiator FSM and a small register-file memory, with a programmable number of wait cycles per read. A separate write port loads the memory contents.

---
 rtl/rd_rsp_pkg.sv | 20 ++
 rtl/rd_rsp_regfile.sv | 47 ++++
 rtl/rd_responder.sv | 140 ++++++++++++++
 tb/tb_rd_responder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rd_rsp_pkg.sv
// rd_rsp_pkg -- shared definitions for the rd_responder read-side responder.
//   rd_state_t   : responder FSM state encoding (IDLE / WAIT / READY)
//   DEF_DW       : default memory word / rdata width
//   DEF_AW       : default address width (depth = 2**AW)
//   DEF_WAIT_CYC : default number of wait cycles per read (0..15)
//   CNT_W        : width of the wait-cycle counter
package rd_rsp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WAIT  = 2'b01,
        READY = 2'b10
    } rd_state_t;

    localparam int DEF_DW       = 8;
    localparam int DEF_AW       = 4;
    localparam int DEF_WAIT_CYC = 2;
    localparam int CNT_W        = 4;

endpackage

// File: rtl/rd_rsp_regfile.sv
// rd_rsp_regfile -- small 2**AW x DW register-file memory behind rd_responder.
// Every word is cleared by the asynchronous reset, so this is built from
// flops rather than block RAM.
// Ports:
//   clk    in  : clock
//   rst_n  in  : asynchronous active-low reset, clears all words to 0
//   we     in  : write enable
//   waddr  in  : write address
//   wdata  in  : write data
//   raddr  in  : read address
//   rdata  out : combinational read data, mem[raddr] (pre-write value on a
//                same-cycle write)
module rd_rsp_regfile
    import rd_rsp_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem_reg [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_reg[gi] <= '0;
                end else if (we && (waddr == AW'(gi))) begin
                    mem_reg[gi] <= wdata;
                end
            end
        end
    endgenerate

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/rd_responder.sv
// rd_responder -- read-side responder for the go/rd/ws/ds read handshake.
// Holds ws high while a read is pending, inserts WAIT_CYC wait cycles, then
// presents the addressed word on rdata and drops ws until rd falls.
// Optional feature macro: RD_RSP_PARITY_EN adds the registered even-parity
// output rpar.
// Ports:
//   clk    in  : clock, all state on rising edge
//   rst_n  in  : asynchronous active-low reset
//   rd     in  : read request, held high for the whole transaction
//   addr   in  : read address, captured when rd is first seen in IDLE
//   we     in  : memory write enable
//   waddr  in  : memory write address
//   wdata  in  : memory write data
//   ws     out : wait state / not ready, low only in READY
//   rdata  out : registered read data, held until the next completed read
//   rpar   out : even parity of rdata (RD_RSP_PARITY_EN only)
module rd_responder
    import rd_rsp_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int AW       = DEF_AW,
    parameter int WAIT_CYC = DEF_WAIT_CYC
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rd,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    output logic          ws,
    output logic [DW-1:0] rdata
`ifdef RD_RSP_PARITY_EN
    ,
    output logic          rpar
`endif
);

    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYC);

    rd_state_t         state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [AW-1:0]     addr_reg;
    logic [DW-1:0]     rdata_reg;
    logic              ws_reg;
    logic [AW-1:0]     mem_raddr;
    logic [DW-1:0]     mem_rdata;
    logic              load_rdata;

    // In IDLE the live address feeds the memory so a zero-wait read can load
    // rdata on the capture edge; afterwards the captured address is used.
    assign mem_raddr = (state_reg == IDLE) ? addr : addr_reg;

    // rdata is loaded exactly on the READY-entry edge. Because the memory read
    // is combinational, a write on that same edge is not yet visible.
    assign load_rdata = rd &&
                        (((state_reg == IDLE) && (WAIT_INIT == '0)) ||
                         ((state_reg == WAIT) && (cnt_reg == CNT_W'(1))));

    rd_rsp_regfile #(
        .DW (DW),
        .AW (AW)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

`ifdef RD_RSP_PARITY_EN
    logic rpar_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            rdata_reg <= '0;
            ws_reg    <= 1'b1;
`ifdef RD_RSP_PARITY_EN
            rpar_reg  <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (rd) begin
                        addr_reg <= addr;
                        if (WAIT_INIT == '0) begin
                            state_reg <= READY;
                            ws_reg    <= 1'b0;
                        end else begin
                            state_reg <= WAIT;
                            cnt_reg   <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    // Counter stops at 1 so it never wraps.
                    if (cnt_reg > CNT_W'(1)) begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                    if (!rd) begin
                        state_reg <= IDLE;
                    end else if (cnt_reg == CNT_W'(1)) begin
                        state_reg <= READY;
                        ws_reg    <= 1'b0;
                    end
                end
                READY: begin
                    if (!rd) begin
                        state_reg <= IDLE;
                        ws_reg    <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    ws_reg    <= 1'b1;
                end
            endcase

            if (load_rdata) begin
                rdata_reg <= mem_rdata;
`ifdef RD_RSP_PARITY_EN
                rpar_reg  <= ^mem_rdata;
`endif
            end
        end
    end

    assign ws    = ws_reg;
    assign rdata = rdata_reg;
`ifdef RD_RSP_PARITY_EN
    assign rpar  = rpar_reg;
`endif

endmodule

// File: tb/tb_rd_responder.sv
// tb_rd_responder -- self-checking bench for rd_responder.
// Three responders with WAIT_CYC = 0, 2 and 3 share one stimulus stream.
// The reference model is transaction level: for a read captured at edge e0
// and held for 'hold' edges, an instance with w wait cycles shows ws=0 after
// edge e0+j when w <= j < hold, and loads rdata from the model memory as it
// stood just before edge e0+w (only if w < hold).
module tb_rd_responder;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int NI = 3;
    localparam int WAITS [NI] = '{0, 2, 3};

    logic                  clk;
    logic                  rst_n;
    logic                  rd;
    logic [AW-1:0]         addr;
    logic                  we;
    logic [AW-1:0]         waddr;
    logic [DW-1:0]         wdata;
    logic [NI-1:0]         ws_v;
    logic [NI-1:0][DW-1:0] rdata_v;
    logic [NI-1:0]         rpar_v;

    int n_total = 0;
    int n_pass  = 0;

    logic [DW-1:0] mem_m     [2**AW];
    logic [DW-1:0] exp_rdata [NI];

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            rd_responder #(
                .DW       (DW),
                .AW       (AW),
                .WAIT_CYC (WAITS[gi])
            ) u_dut (
                .clk   (clk),
                .rst_n (rst_n),
                .rd    (rd),
                .addr  (addr),
                .we    (we),
                .waddr (waddr),
                .wdata (wdata),
                .ws    (ws_v[gi]),
                .rdata (rdata_v[gi])
`ifdef RD_RSP_PARITY_EN
                ,
                .rpar  (rpar_v[gi])
`endif
            );
`ifndef RD_RSP_PARITY_EN
            assign rpar_v[gi] = 1'b0;
`endif
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare every instance's outputs with the model.
    task automatic check_all(input string tag, input logic [NI-1:0] exp_ws);
        for (int i = 0; i < NI; i++) begin
            n_total++;
            if (ws_v[i] !== exp_ws[i])
                $display("FAIL %s ws w=%0d: got %0b expected %0b", tag, WAITS[i], ws_v[i], exp_ws[i]);
            else
                n_pass++;
            n_total++;
            if (rdata_v[i] !== exp_rdata[i])
                $display("FAIL %s rdata w=%0d: got %02h expected %02h", tag, WAITS[i], rdata_v[i], exp_rdata[i]);
            else
                n_pass++;
`ifdef RD_RSP_PARITY_EN
            n_total++;
            if (rpar_v[i] !== (^exp_rdata[i]))
                $display("FAIL %s rpar w=%0d: got %0b expected %0b", tag, WAITS[i], rpar_v[i], ^exp_rdata[i]);
            else
                n_pass++;
`endif
        end
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        rd = 1'b0; we = 1'b1; waddr = a; wdata = d;
        @(posedge clk);
        mem_m[a] = d;
        #1;
        we = 1'b0;
        check_all("idle_write", '1);
        $display("write mem[%0d]=%02h", a, d);
    endtask

    // One read transaction; wr_j >= 0 plants a write on edge e0+wr_j.
    task automatic do_read(input string tag, input logic [AW-1:0] a, input int hold,
                           input int wr_j, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        logic [NI-1:0] exp_ws;
        for (int j = 0; j <= hold; j++) begin
            rd    = (j < hold);
            addr  = (j == 0) ? a : AW'($urandom);
            we    = (j == wr_j);
            waddr = wa;
            wdata = wd;
            @(posedge clk);
            for (int i = 0; i < NI; i++) begin
                if (j < hold && j == WAITS[i]) exp_rdata[i] = mem_m[a];
                exp_ws[i] = !(j < hold && j >= WAITS[i]);
            end
            if (j == wr_j) mem_m[wa] = wd;
            #1;
            check_all(tag, exp_ws);
        end
        rd = 1'b0; we = 1'b0;
        $display("read %s addr=%0d hold=%0d wr_j=%0d -> rdata %02h/%02h/%02h", tag, a, hold, wr_j,
                 rdata_v[0], rdata_v[1], rdata_v[2]);
    endtask

    task automatic test_reset;
        for (int i = 0; i < NI; i++) exp_rdata[i] = '0;
        check_all("reset_state", '1);
        $display("reset state checked");
    endtask

    task automatic test_zero_wait;
        write_word(4'd3, 8'hA5);
        do_read("zero_wait", 4'd3, 3, -1, '0, '0);
    endtask

    task automatic test_two_wait;
        write_word(4'd7, 8'h3C);
        do_read("two_wait", 4'd7, 4, -1, '0, '0);
    endtask

    task automatic test_abort;
        write_word(4'd9, 8'h5A);
        do_read("abort", 4'd9, 2, -1, '0, '0);
    endtask

    task automatic test_collision;
        write_word(4'd5, 8'h11);
        do_read("coll_early", 4'd5, 4, 1, 4'd5, 8'h22);
        write_word(4'd5, 8'h11);
        do_read("coll_ready_edge", 4'd5, 4, 2, 4'd5, 8'h22);
    endtask

    task automatic test_parity;
        write_word(4'd1, 8'h07);
        do_read("parity_07", 4'd1, 5, -1, '0, '0);
        write_word(4'd2, 8'h03);
        do_read("parity_03", 4'd2, 5, -1, '0, '0);
    endtask

    task automatic test_back_to_back;
        write_word(4'd10, 8'hC3);
        write_word(4'd11, 8'h81);
        do_read("b2b_0", 4'd10, 4, -1, '0, '0);
        do_read("b2b_1", 4'd11, 4, -1, '0, '0);
    endtask

    task automatic test_reset_mid;
        rd = 1'b1; addr = 4'd3; we = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int a = 0; a < 2**AW; a++) mem_m[a] = '0;
        for (int i = 0; i < NI; i++) exp_rdata[i] = '0;
        check_all("reset_mid_async", '1);
        @(negedge clk);
        rd = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("reset_mid_release", '1);
        $display("mid-transaction reset checked");
        // Memory must have been cleared: address 3 held A5 before reset.
        do_read("after_reset", 4'd3, 5, -1, '0, '0);
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++) begin
            int hold;
            int wj;
            logic [AW-1:0] a;
            logic [AW-1:0] wa;
            a    = AW'($urandom);
            hold = $urandom_range(1, 6);
            wj   = $urandom_range(0, 3) == 0 ? -1 : int'($urandom_range(0, hold));
            wa   = ($urandom_range(0, 1) == 1) ? a : AW'($urandom);
            if ($urandom_range(0, 2) == 0) write_word(AW'($urandom), DW'($urandom));
            do_read("random", a, hold, wj, wa, DW'($urandom));
        end
    endtask

    initial begin
        rst_n = 1'b0; rd = 1'b0; addr = '0; we = 1'b0; waddr = '0; wdata = '0;
        for (int a = 0; a < 2**AW; a++) mem_m[a] = '0;
        for (int i = 0; i < NI; i++) exp_rdata[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset;
        test_zero_wait;
        test_two_wait;
        test_abort;
        test_collision;
        test_parity;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
